// File: rtl/transrf_b4r5g3_pkg.sv
// Shared sizing for the nibble-to-row transposing register file.
package transrf_b4r5g3_pkg;
  localparam int B     = 4;
  localparam int R     = 5;
  localparam int G     = 3;
  localparam int RW    = R * B;
  localparam int NSLOT = R * G;
  localparam int CNTW  = $clog2(NSLOT + 1);
  localparam int WCW   = $clog2(R);
  localparam int GW    = $clog2(G);
endpackage

// File: rtl/transrf_b4r5g3_if.sv
// Producer/consumer bundle; master is the datapath side, slave is the register file.
interface transrf_b4r5g3_if;
  import transrf_b4r5g3_pkg::*;

  logic          w_en;
  logic [B-1:0]  w_data;
  logic          r_en;
  logic [RW-1:0] r_data;
  logic          rf_full;
  logic          rf_empty;

  modport master (
    output w_en, w_data, r_en,
    input  r_data, rf_full, rf_empty
  );

  modport slave (
    input  w_en, w_data, r_en,
    output r_data, rf_full, rf_empty
  );
endinterface

// File: rtl/transrf_b4r5g3_ptr.sv
// Modulo-N incrementing pointer shared by the column, write-row and read-row indices.
module transrf_b4r5g3_ptr #(
  parameter int N = 3,
  parameter int W = 2
) (
  input  logic         clk_w,
  input  logic         rst_n,
  input  logic         inc,
  output logic [W-1:0] val
);
  logic at_last;

  assign at_last = (val == W'(N - 1));

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      val <= '0;
    end else if (inc) begin
      val <= at_last ? '0 : val + W'(1);
    end
  end
endmodule

// File: rtl/transrf_b4r5g3.sv
// Packs R nibbles per row into a G-row flop array and pops whole rows in FIFO order.
module transrf_b4r5g3
  import transrf_b4r5g3_pkg::*;
(
  input  logic             clk_w,
  input  logic             rst_n,
  transrf_b4r5g3_if.slave  bus
);
  logic [CNTW-1:0] cnt;
  logic [WCW-1:0]  wc;
  logic [GW-1:0]   wr;
  logic [GW-1:0]   rr;
  logic [RW-1:0]   mem [G];
  logic [RW-1:0]   r_data_q;
  logic            full;
  logic            empty;
  logic            w_acc;
  logic            r_acc;
  logic            wc_last;

  // Flags decode pre-edge count, so a same-cycle read never frees room for a write
  // and a same-cycle row completion never makes a read legal.
  assign full    = (cnt == CNTW'(NSLOT));
  assign empty   = (cnt < CNTW'(R));
  assign w_acc   = bus.w_en && !full;
  assign r_acc   = bus.r_en && !empty;
  assign wc_last = (wc == WCW'(R - 1));

  assign bus.rf_full  = full;
  assign bus.rf_empty = empty;
  assign bus.r_data   = r_data_q;

  transrf_b4r5g3_ptr #(.N(R), .W(WCW)) u_wc (
    .clk_w (clk_w),
    .rst_n (rst_n),
    .inc   (w_acc),
    .val   (wc)
  );

  transrf_b4r5g3_ptr #(.N(G), .W(GW)) u_wr (
    .clk_w (clk_w),
    .rst_n (rst_n),
    .inc   (w_acc && wc_last),
    .val   (wr)
  );

  transrf_b4r5g3_ptr #(.N(G), .W(GW)) u_rr (
    .clk_w (clk_w),
    .rst_n (rst_n),
    .inc   (r_acc),
    .val   (rr)
  );

  always_ff @(posedge clk_w) begin
    if (w_acc) begin
      mem[wr][int'(wc) * B +: B] <= bus.w_data;
    end
  end

  always_ff @(posedge clk_w or negedge rst_n) begin
    if (!rst_n) begin
      cnt      <= '0;
      r_data_q <= '0;
    end else begin
      cnt <= cnt + CNTW'(w_acc) - (r_acc ? CNTW'(R) : CNTW'(0));
      if (r_acc) begin
        r_data_q <= mem[rr];
      end
    end
  end
endmodule

// File: tb/tb_transrf_b4r5g3.sv
// Directed vector table, reset sequences and a queue-scoreboarded random stress run.
module tb_transrf_b4r5g3;
  logic clk_w;
  logic rst_n;

  transrf_b4r5g3_if bus ();

  transrf_b4r5g3 dut (
    .clk_w (clk_w),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk_w = 1'b0;
  always #5 clk_w = ~clk_w;

  typedef struct {
    logic        we;
    logic [3:0]  wd;
    logic        re;
    logic [19:0] rd;
    logic        full;
    logic        empty;
  } vec_t;

  vec_t        vecs[$];
  logic [19:0] exp_rows[$];
  int          checks;
  int          errors;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic add(input logic we, input logic [3:0] wd, input logic re,
                     input logic [19:0] rd, input logic full, input logic empty);
    vec_t v;
    v.we = we; v.wd = wd; v.re = re; v.rd = rd; v.full = full; v.empty = empty;
    vecs.push_back(v);
  endtask

  task automatic cyc(input logic we, input logic [3:0] wd, input logic re);
    bus.w_en   = we;
    bus.w_data = wd;
    bus.r_en   = re;
    @(posedge clk_w);
    #1;
  endtask

  task automatic check_outs(input string tag, input logic [19:0] rd, input logic full, input logic empty);
    check({tag, " r_data"}, 32'(bus.r_data), 32'(rd));
    check({tag, " rf_full"}, 32'(bus.rf_full), 32'(full));
    check({tag, " rf_empty"}, 32'(bus.rf_empty), 32'(empty));
  endtask

  initial begin
    logic [3:0]  nib;
    logic [19:0] part;
    logic [19:0] last;
    logic [19:0] exp_row;
    int          pc;
    int          m_cnt;
    logic        we;
    logic        re;
    logic        w_acc;
    logic        r_acc;

    checks = 0;
    errors = 0;
    rst_n = 1'b0;
    bus.w_en = 1'b0;
    bus.w_data = 4'h0;
    bus.r_en = 1'b0;

    // Reset held: inputs toggling must not disturb anything.
    for (int i = 0; i < 4; i++) cyc(1'b1, 4'(i + 3), i[0]);
    check_outs("reset_hold", 20'h0, 1'b0, 1'b1);
    bus.w_en = 1'b0;
    bus.r_en = 1'b0;
    rst_n = 1'b1;
    #2;

    // Single row, then read.
    for (int i = 1; i <= 5; i++) add(1'b1, 4'(i), 1'b0, 20'h0, 1'b0, i < 5);
    add(1'b0, 4'h0, 1'b1, 20'h54321, 1'b0, 1'b1);
    // Fill to full, overflow write ignored, drain three rows.
    for (int i = 1; i <= 15; i++) add(1'b1, 4'(i), 1'b0, 20'h54321, i == 15, i < 5);
    add(1'b1, 4'h0, 1'b0, 20'h54321, 1'b1, 1'b0);
    add(1'b0, 4'h0, 1'b1, 20'h54321, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b1, 20'hA9876, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b1, 20'hFEDCB, 1'b0, 1'b1);
    // Read while empty holds r_data; partial row stays unreadable.
    add(1'b0, 4'h0, 1'b1, 20'hFEDCB, 1'b0, 1'b1);
    for (int i = 1; i <= 4; i++) add(1'b1, 4'(i), 1'b0, 20'hFEDCB, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b1, 20'hFEDCB, 1'b0, 1'b1);
    add(1'b1, 4'h5, 1'b0, 20'hFEDCB, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b1, 20'h54321, 1'b0, 1'b1);
    // Read rejected although the same-cycle write completes a row.
    for (int i = 6; i <= 9; i++) add(1'b1, 4'(i), 1'b0, 20'h54321, 1'b0, 1'b1);
    add(1'b1, 4'hA, 1'b1, 20'h54321, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b1, 20'hA9876, 1'b0, 1'b1);
    // Concurrent write+read at full: read wins, write dropped, cnt 15 -> 10.
    for (int i = 1; i <= 15; i++) add(1'b1, 4'(i), 1'b0, 20'hA9876, i == 15, i < 5);
    add(1'b1, 4'h0, 1'b1, 20'h54321, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b1, 20'hA9876, 1'b0, 1'b0);
    add(1'b0, 4'h0, 1'b1, 20'hFEDCB, 1'b0, 1'b1);
    add(1'b0, 4'h0, 1'b1, 20'hFEDCB, 1'b0, 1'b1);

    for (int i = 0; i < vecs.size(); i++) begin
      cyc(vecs[i].we, vecs[i].wd, vecs[i].re);
      check_outs($sformatf("vec%0d", i), vecs[i].rd, vecs[i].full, vecs[i].empty);
    end

    // Mid-stream asynchronous reset: 7 nibbles buffered, then reset between edges.
    for (int i = 0; i < 7; i++) cyc(1'b1, 4'(i), 1'b0);
    check("pre_reset rf_empty", 32'(bus.rf_empty), 32'd0);
    bus.w_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check_outs("async_reset", 20'h0, 1'b0, 1'b1);
    #1;
    rst_n = 1'b1;
    @(posedge clk_w);
    #1;
    // Partial data was discarded: a fresh row needs all five nibbles.
    for (int i = 1; i <= 4; i++) cyc(1'b1, 4'(i + 10), 1'b0);
    check("post_reset partial", 32'(bus.rf_empty), 32'd1);
    cyc(1'b1, 4'hF, 1'b1);
    check("post_reset rejected read", 32'(bus.r_data), 32'h0);
    cyc(1'b0, 4'h0, 1'b1);
    check("post_reset row", 32'(bus.r_data), 32'hFEDCB);
    check("post_reset empty", 32'(bus.rf_empty), 32'd1);

    // Random stress against a queue scoreboard; cnt is 0 here.
    nib = 4'h0; part = '0; pc = 0; m_cnt = 0; last = 20'hFEDCB;
    for (int n = 0; n < 600; n++) begin
      we = ($urandom_range(0, 9) < 6);
      re = ($urandom_range(0, 1) == 1);
      w_acc = we && (m_cnt != 15);
      r_acc = re && (exp_rows.size() != 0);
      cyc(we, nib, re);
      if (w_acc) begin
        part[pc * 4 +: 4] = nib;
        pc++;
        if (pc == 5) begin
          exp_rows.push_back(part);
          pc = 0;
        end
        nib = nib + 4'h1;
        m_cnt++;
      end
      if (r_acc) begin
        exp_row = exp_rows.pop_front();
        last = exp_row;
        m_cnt -= 5;
      end
      check($sformatf("stress%0d r_data", n), 32'(bus.r_data), 32'(last));
      check($sformatf("stress%0d rf_full", n), 32'(bus.rf_full), 32'(m_cnt == 15));
      check($sformatf("stress%0d rf_empty", n), 32'(bus.rf_empty), 32'(exp_rows.size() == 0));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
